// File: rtl/rom_bridge_pkg.sv
// rom_bridge_pkg: shared encodings and constants for the ROM read bridge
package rom_bridge_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
    typedef enum logic [1:0] {SIZE_8 = 2'd0, SIZE_16 = 2'd1, SIZE_32 = 2'd2} size_t;
    localparam logic [1:0] SETTLE_LOW = 2'd2;
    function automatic logic [1:0] last_index(input logic [1:0] size);
        return size == SIZE_16 ? 2'd1 : size == SIZE_32 ? 2'd3 : 2'd0;
    endfunction
endpackage

// File: rtl/rom_read_bridge.sv
// rom_read_bridge: splits 8/16/32-bit reads into settled byte reads against the paged ROM
module rom_read_bridge
    import rom_bridge_pkg::*;
#(
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_address,
    input  logic [1:0]  req_size,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [23:0] rom_address,
    output logic        rom_enable,
    input  logic        rom_busy,
    input  logic [7:0]  rom_data
);
    state_t                  state, state_nx;
    logic [23:0]             base_addr;
    logic [1:0]              idx, last_idx, low_cnt;
    logic [TIMEOUT_BITS-1:0] tmr;
    logic [31:0]             data_q;
    logic                    err_q, capture, timeout;

    // a byte is taken on its second consecutive busy-low sample; timeout only when no capture
    always_comb begin
        capture     = state == WAIT && !rom_busy && low_cnt == SETTLE_LOW - 2'd1;
        timeout     = state == WAIT && !capture && &tmr;
        state_nx    = state == IDLE  ? (req_valid ? ISSUE : IDLE) :
                      state == ISSUE ? WAIT :
                      state == WAIT  ? (capture ? (idx == last_idx ? DONE : ISSUE) : timeout ? DONE : WAIT) :
                      IDLE;
        req_ready   = state == IDLE;
        rom_enable  = state == ISSUE || state == WAIT;
        resp_valid  = state == DONE;
        rom_address = base_addr + {22'd0, idx};
        resp_data   = data_q;
        resp_error  = err_q;
    end

    // state, request latch, settle/timeout counters and little-endian byte-lane assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base_addr <= '0;
            idx       <= '0;
            last_idx  <= '0;
            low_cnt   <= '0;
            tmr       <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                base_addr <= req_address;
                last_idx  <= last_index(req_size);
                idx       <= '0;
                data_q    <= '0;
                err_q     <= 1'b0;
            end
            if (state == ISSUE) begin
                low_cnt <= '0;
                tmr     <= '0;
            end
            if (state == WAIT) begin
                low_cnt <= rom_busy ? 2'd0 : low_cnt + 2'd1;
                tmr     <= tmr + 1'b1;
            end
            if (capture) begin
                data_q[{idx, 3'b000} +: 8] <= rom_data;
                if (idx != last_idx) idx <= idx + 2'd1;
            end
            if (timeout) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rom_read_bridge.sv
// tb_rom_read_bridge: table-driven and scoreboard checks of rom_read_bridge against an sd_card model
module tb_rom_read_bridge;
    typedef struct {
        logic [23:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic        err;
        int          lat;
    } vec_t;
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        rv0 = 0, rdy0, vld0, re0, ren0, busy0 = 0;
    logic [23:0] ra0 = 0, radr0;
    logic [1:0]  rs0 = 0;
    logic [31:0] rd0;
    logic [7:0]  rdat0 = 0;
    logic        rv1 = 0, rdy1, vld1, re1, ren1, busy1 = 0;
    logic [23:0] ra1 = 0, radr1;
    logic [1:0]  rs1 = 0;
    logic [31:0] rd1;
    logic [7:0]  rdat1 = 0;

    rom_read_bridge dut (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rdy0), .req_address(ra0),
        .req_size(rs0), .resp_valid(vld0), .resp_data(rd0), .resp_error(re0),
        .rom_address(radr0), .rom_enable(ren0), .rom_busy(busy0), .rom_data(rdat0)
    );
    rom_read_bridge #(.TIMEOUT_BITS(4)) dut_to (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1), .req_address(ra1),
        .req_size(rs1), .resp_valid(vld1), .resp_data(rd1), .resp_error(re1),
        .rom_address(radr1), .rom_enable(ren1), .rom_busy(busy1), .rom_data(rdat1)
    );

    int checks = 0, errors = 0, cyc = 0, last_acc = 0;
    exp_t q0[$], q1[$];
    logic [23:0] alog[$];
    logic        pen = 0;
    logic [23:0] padr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_at(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hA5;
            24'h000020: return 8'h11;
            24'h000021: return 8'h22;
            24'h000022: return 8'h33;
            24'h000023: return 8'h44;
            24'h000200: return 8'h5A;
            default:    return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // paged sd_card model: 512-byte pages, 40-cycle fill, one stale-data cycle after busy falls
    logic [14:0] page0 = 0;
    int          fill0 = 0;
    always @(posedge clk) begin
        if (ren0) begin
            if (fill0 > 0) begin
                fill0 <= fill0 - 1;
                if (fill0 == 1) begin
                    busy0 <= 1'b0;
                    page0 <= radr0[23:9];
                    rdat0 <= 8'hEE;
                end
            end else if (radr0[23:9] != page0) begin
                busy0 <= 1'b1;
                fill0 <= 40;
            end else begin
                busy0 <= 1'b0;
                rdat0 <= mem_at(radr0);
            end
        end
    end

    // always-hit model for the timeout instance, busy forced by stuck1
    logic stuck1 = 0;
    always @(posedge clk) begin
        busy1 <= stuck1;
        if (ren1) rdat1 <= mem_at(radr1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (vld0) begin
            if (q0.size() == 0) chk("unexpected_resp0", vld0, 1'b0);
            else begin
                e = q0.pop_front();
                chk("resp_data0", rd0, e.data);
                chk("resp_error0", re0, e.err);
                if (e.lat > 0) chk("latency0", cyc - e.acc, e.lat);
            end
        end
        if (ren0 && (!pen || radr0 != padr)) alog.push_back(radr0);
        pen  <= ren0;
        padr <= radr0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (vld1) begin
            if (q1.size() == 0) chk("unexpected_resp1", vld1, 1'b0);
            else begin
                e = q1.pop_front();
                chk("resp_data1", rd1, e.data);
                chk("resp_error1", re1, e.err);
                if (e.lat > 0) chk("latency1", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic send(input bit u, input logic [23:0] a, input logic [1:0] s,
                        input logic [31:0] d, input logic e, input int lat, input bit expect_resp);
        int n = 0;
        @(negedge clk);
        #1;
        while (!(u ? rdy1 : rdy0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("ready_wait", 1'b0, 1'b1);
        else begin
            if (u) begin rv1 = 1; ra1 = a; rs1 = s; end
            else   begin rv0 = 1; ra0 = a; rs0 = s; end
            last_acc = cyc;
            if (expect_resp) begin
                if (u) q1.push_back('{d, e, lat, cyc});
                else   q0.push_back('{d, e, lat, cyc});
            end
            @(posedge clk);
            #1;
            rv0 = 0;
            rv1 = 0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", q0.size() + q1.size(), 0);
    endtask

    task automatic chk_log(input string name, input logic [23:0] exp[$]);
        chk({name, "_len"}, alog.size(), exp.size());
        for (int i = 0; i < alog.size() && i < exp.size(); i++) chk(name, alog[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        int   acc_a, n;
        tbl[0] = '{24'h000010, 2'd0, 32'h000000A5, 1'b0, 4};
        tbl[1] = '{24'h000020, 2'd2, 32'h44332211, 1'b0, 13};
        tbl[2] = '{24'h000020, 2'd1, 32'h00002211, 1'b0, 7};
        tbl[3] = '{24'h000021, 2'd3, 32'h00000022, 1'b0, 4};
        tbl[4] = '{24'h0001FF, 2'd1, 32'h00005AC3, 1'b0, 47};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_valid", vld0, 1'b0);
        chk("rst_data", rd0, 32'h0);
        chk("rst_error", re0, 1'b0);
        chk("rst_enable", ren0, 1'b0);
        chk("rst_address", radr0, 24'h0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 5; i++) send(0, tbl[i].addr, tbl[i].size, tbl[i].data, tbl[i].err, tbl[i].lat, 1);
        wait_idle();

        alog.delete();
        send(0, 24'h000020, 2'd2, 32'h44332211, 1'b0, 0, 1);
        wait_idle();
        chk_log("addr_seq4", '{24'h20, 24'h21, 24'h22, 24'h23});

        alog.delete();
        send(0, 24'hFFFFFF, 2'd1, 32'h00003CC3, 1'b0, 0, 1);
        wait_idle();
        chk_log("addr_wrap", '{24'hFFFFFF, 24'h000000});

        send(0, 24'h000010, 2'd0, 32'h000000A5, 1'b0, 4, 1);
        acc_a = last_acc;
        send(0, 24'h000021, 2'd0, 32'h00000022, 1'b0, 4, 1);
        chk("back_to_back_gap", last_acc - acc_a, 5);
        wait_idle();

        @(negedge clk);
        stuck1 = 1;
        send(1, 24'h000010, 2'd2, 32'h0, 1'b1, 18, 1);
        chk("busy_not_ready", rdy1, 1'b0);
        wait_idle();
        stuck1 = 0;
        send(1, 24'h000020, 2'd1, 32'h00002211, 1'b0, 7, 1);
        wait_idle();

        send(0, 24'h000020, 2'd2, 32'h0, 1'b0, 0, 0);
        n = 0;
        while (!(ren0 && radr0 == 24'h000022) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_byte2", n < 100, 1'b1);
        @(negedge clk);
        chk("wait_not_ready", rdy0, 1'b0);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        chk("midrst_enable", ren0, 1'b0);
        chk("midrst_ready", rdy0, 1'b1);
        chk("midrst_valid", vld0, 1'b0);
        chk("midrst_data", rd0, 32'h0);
        @(negedge clk);
        reset = 0;
        repeat (20) @(negedge clk);
        send(0, 24'h000010, 2'd0, 32'h000000A5, 1'b0, 4, 1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
